// File: rtl/oled_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module   : oled_spi_rx
//  Purpose  : Receive side of a 4-wire write-only OLED SPI link. Oversamples
//             CSb/DCb/SDCLK/SDIN on CLK, deserialises MSB-first bytes,
//             decodes column/row window and write-RAM commands and emits
//             RGB565 framebuffer pixel writes.
//  Revision : 1.0  initial release
// ============================================================================
module oled_spi_rx #(
    parameter int WIDTH       = 128,
    parameter int HEIGHT      = 128,
    parameter int ADDR_W      = 14,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK,
    input  logic              RSTb,
    input  logic              OLED_CSb,
    input  logic              OLED_DCb,
    input  logic              OLED_SDCLK,
    input  logic              OLED_SDIN,
    output logic              rx_valid,
    output logic              rx_dc,
    output logic [7:0]        rx_byte,
    output logic              pix_valid,
    output logic [ADDR_W-1:0] pix_addr,
    output logic [15:0]       pix_data,
    output logic              frame_done,
    output logic              abort_err
);

    // Four inputs travel side by side through the synchroniser chain:
    // bit 3 = CSb, bit 2 = DCb, bit 1 = SDCLK, bit 0 = SDIN.
    localparam int                c_sync_w  = 4 * SYNC_STAGES;
    localparam logic [7:0]        c_col_max = 8'(WIDTH - 1);
    localparam logic [7:0]        c_row_max = 8'(HEIGHT - 1);
    localparam logic [ADDR_W-1:0] c_width_a = ADDR_W'(WIDTH);

    localparam logic [7:0] c_cmd_col  = 8'h15;
    localparam logic [7:0] c_cmd_row  = 8'h75;
    localparam logic [7:0] c_cmd_wram = 8'h5C;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COL_S = 3'd1,
        S_COL_E = 3'd2,
        S_ROW_S = 3'd3,
        S_ROW_E = 3'd4,
        S_WRAM  = 3'd5
    } state_t;

    logic [c_sync_w-1:0] r_sync;
    logic [3:0]          w_spi;
    logic                w_csb;
    logic                w_dcb;
    logic                w_sck;
    logic                w_sdin;
    logic                r_sck_d;
    logic                w_sck_rise;

    logic [6:0]          r_shift;
    logic [2:0]          r_bitcnt;

    state_t              r_state;
    state_t              w_state_nxt;

    logic [7:0]          r_col_start;
    logic [7:0]          r_col_end;
    logic [7:0]          r_row_start;
    logic [7:0]          r_row_end;
    logic [7:0]          r_col;
    logic [7:0]          r_row;
    logic                r_pending;
    logic [7:0]          r_high;

    logic [7:0]          w_clamp_col;
    logic [7:0]          w_clamp_row;
    logic                w_is_cmd;
    logic                w_is_data;
    logic                w_pix_fire;
    logic [ADDR_W-1:0]   w_addr;

    assign w_spi      = r_sync[c_sync_w-1 -: 4];
    assign w_csb      = w_spi[3];
    assign w_dcb      = w_spi[2];
    assign w_sck      = w_spi[1];
    assign w_sdin     = w_spi[0];
    assign w_sck_rise = w_sck & ~r_sck_d;

    // Synchroniser chain; CSb and SDCLK reset to their idle-high levels
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_sync  <= {SYNC_STAGES{4'b1010}};
            r_sck_d <= 1'b1;
        end else begin
            r_sync  <= {r_sync[c_sync_w-5:0], OLED_CSb, OLED_DCb, OLED_SDCLK, OLED_SDIN};
            r_sck_d <= w_sck;
        end
    end

    // Deserialiser: shift on SDCLK rise, emit a byte every 8 bits, flag partial bytes
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_shift   <= '0;
            r_bitcnt  <= '0;
            rx_valid  <= 1'b0;
            rx_dc     <= 1'b0;
            rx_byte   <= '0;
            abort_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            abort_err <= 1'b0;
            if (w_csb) begin
                r_bitcnt  <= '0;
                abort_err <= (r_bitcnt != 3'd0);
            end else if (w_sck_rise) begin
                r_shift <= {r_shift[5:0], w_sdin};
                if (r_bitcnt == 3'd7) begin
                    rx_valid <= 1'b1;
                    rx_byte  <= {r_shift, w_sdin};
                    rx_dc    <= w_dcb;
                    r_bitcnt <= '0;
                end else begin
                    r_bitcnt <= r_bitcnt + 3'd1;
                end
            end
        end
    end

    assign w_is_cmd    = rx_valid & ~rx_dc;
    assign w_is_data   = rx_valid & rx_dc;
    assign w_clamp_col = (rx_byte > c_col_max) ? c_col_max : rx_byte;
    assign w_clamp_row = (rx_byte > c_row_max) ? c_row_max : rx_byte;
    assign w_pix_fire  = w_is_data && (r_state == S_WRAM) && r_pending;
    assign w_addr      = ADDR_W'(r_row) * c_width_a + ADDR_W'(r_col);

    // Command state register
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Command decode: opcodes pick the state, data bytes walk the window argument sequence
    always_comb begin
        w_state_nxt = r_state;
        if (w_is_cmd) begin
            case (rx_byte)
                c_cmd_col:  w_state_nxt = S_COL_S;
                c_cmd_row:  w_state_nxt = S_ROW_S;
                c_cmd_wram: w_state_nxt = S_WRAM;
                default:    w_state_nxt = S_IDLE;
            endcase
        end else if (w_is_data) begin
            case (r_state)
                S_COL_S: w_state_nxt = S_COL_E;
                S_COL_E: w_state_nxt = S_IDLE;
                S_ROW_S: w_state_nxt = S_ROW_E;
                S_ROW_E: w_state_nxt = S_IDLE;
                default: w_state_nxt = r_state;
            endcase
        end
    end

    // Window registers, pixel assembly and write-pointer advance
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            r_col_start <= '0;
            r_col_end   <= c_col_max;
            r_row_start <= '0;
            r_row_end   <= c_row_max;
            r_col       <= '0;
            r_row       <= '0;
            r_pending   <= 1'b0;
            r_high      <= '0;
            pix_valid   <= 1'b0;
            pix_addr    <= '0;
            pix_data    <= '0;
            frame_done  <= 1'b0;
        end else begin
            pix_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (w_is_cmd) begin
                r_pending <= 1'b0;
            end else if (w_is_data) begin
                case (r_state)
                    S_COL_S: r_col_start <= w_clamp_col;
                    S_COL_E: begin
                        // An inverted window collapses to a single column
                        r_col_end <= (w_clamp_col < r_col_start) ? r_col_start : w_clamp_col;
                        r_col     <= r_col_start;
                    end
                    S_ROW_S: r_row_start <= w_clamp_row;
                    S_ROW_E: begin
                        r_row_end <= (w_clamp_row < r_row_start) ? r_row_start : w_clamp_row;
                        r_row     <= r_row_start;
                    end
                    S_WRAM: begin
                        if (!r_pending) begin
                            r_high    <= rx_byte;
                            r_pending <= 1'b1;
                        end else begin
                            r_pending <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end

            if (w_pix_fire) begin
                pix_valid <= 1'b1;
                pix_data  <= {r_high, rx_byte};
                pix_addr  <= w_addr;
                if (r_col == r_col_end) begin
                    r_col <= r_col_start;
                    if (r_row == r_row_end) begin
                        r_row      <= r_row_start;
                        frame_done <= 1'b1;
                    end else begin
                        r_row <= r_row + 8'd1;
                    end
                end else begin
                    r_col <= r_col + 8'd1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_oled_spi_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_oled_spi_rx
//  Purpose  : Directed, scoreboard-checked bench for oled_spi_rx. Stimulus
//             pushes expected bytes/pixels/aborts; a monitor pops and
//             compares whenever the DUT pulses an output.
//  Revision : 1.0  initial release
// ============================================================================
module tb_oled_spi_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        csb = 1'b1;
    logic        dcb = 1'b0;
    logic        sck = 1'b1;
    logic        sdin = 1'b0;

    logic        rx_valid;
    logic        rx_dc;
    logic [7:0]  rx_byte;
    logic        pix_valid;
    logic [13:0] pix_addr;
    logic [15:0] pix_data;
    logic        frame_done;
    logic        abort_err;

    typedef struct packed {
        logic       dc;
        logic [7:0] b;
    } rx_t;

    typedef struct packed {
        logic [13:0] a;
        logic [15:0] d;
        logic        fd;
    } pix_t;

    rx_t  q_rx[$];
    pix_t q_pix[$];
    int   n_abort_exp = 0;
    int   tests = 0;
    int   failed = 0;

    oled_spi_rx #(
        .WIDTH      (128),
        .HEIGHT     (128),
        .ADDR_W     (14),
        .SYNC_STAGES(2)
    ) dut (
        .CLK       (clk),
        .RSTb      (rst_n),
        .OLED_CSb  (csb),
        .OLED_DCb  (dcb),
        .OLED_SDCLK(sck),
        .OLED_SDIN (sdin),
        .rx_valid  (rx_valid),
        .rx_dc     (rx_dc),
        .rx_byte   (rx_byte),
        .pix_valid (pix_valid),
        .pix_addr  (pix_addr),
        .pix_data  (pix_data),
        .frame_done(frame_done),
        .abort_err (abort_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            sck  = 1'b0;
            sdin = b[i];
            tick(2);
            sck  = 1'b1;
            tick(2);
        end
    endtask

    // One framed byte: DCb settles while CSb is high, CSb framed around it
    task automatic spi_byte(input logic dc, input logic [7:0] b);
        q_rx.push_back('{dc: dc, b: b});
        dcb = dc;
        tick(2);
        csb = 1'b0;
        tick(2);
        shift_bits(b, 8);
        tick(2);
        csb = 1'b1;
        tick(2);
    endtask

    task automatic cmd(input logic [7:0] b);
        spi_byte(1'b0, b);
    endtask

    task automatic dat(input logic [7:0] b);
        spi_byte(1'b1, b);
    endtask

    task automatic pixel(input logic [13:0] a, input logic [15:0] d, input logic fd);
        q_pix.push_back('{a: a, d: d, fd: fd});
        dat(d[15:8]);
        dat(d[7:0]);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rx_valid"},   32'(rx_valid),   32'h0);
        chk({tag, "_rx_dc"},      32'(rx_dc),      32'h0);
        chk({tag, "_rx_byte"},    32'(rx_byte),    32'h0);
        chk({tag, "_pix_valid"},  32'(pix_valid),  32'h0);
        chk({tag, "_pix_addr"},   32'(pix_addr),   32'h0);
        chk({tag, "_pix_data"},   32'(pix_data),   32'h0);
        chk({tag, "_frame_done"}, 32'(frame_done), 32'h0);
        chk({tag, "_abort_err"},  32'(abort_err),  32'h0);
    endtask

    // Monitor: pop and compare on every DUT output pulse
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) begin
                if (q_rx.size() == 0) begin
                    chk("rx_unexpected", 32'(rx_byte), 32'hFFFF_FFFF);
                end else begin
                    rx_t e;
                    e = q_rx.pop_front();
                    chk("rx_dc", 32'(rx_dc), 32'(e.dc));
                    chk("rx_byte", 32'(rx_byte), 32'(e.b));
                end
            end
            if (pix_valid) begin
                if (q_pix.size() == 0) begin
                    chk("pix_unexpected", 32'(pix_addr), 32'hFFFF_FFFF);
                end else begin
                    pix_t p;
                    p = q_pix.pop_front();
                    chk("pix_addr", 32'(pix_addr), 32'(p.a));
                    chk("pix_data", 32'(pix_data), 32'(p.d));
                    chk("frame_done", 32'(frame_done), 32'(p.fd));
                end
            end else if (frame_done) begin
                chk("frame_done_without_pixel", 32'(frame_done), 32'h0);
            end
            if (abort_err) begin
                if (n_abort_exp == 0) begin
                    chk("abort_unexpected", 32'(abort_err), 32'h0);
                end else begin
                    n_abort_exp--;
                    chk("abort_err", 32'(abort_err), 32'h1);
                end
            end
        end
    end

    logic [13:0] t2_addr [10] = '{14'h1010, 14'h1011, 14'h1012, 14'h1013,
                                  14'h1090, 14'h1091, 14'h1092, 14'h1093,
                                  14'h1010, 14'h1011};

    initial begin
        int wait_cnt;
        tick(3);
        #1;
        check_all_zero("reset");
        tick(2);
        rst_n = 1'b1;
        tick(4);

        // 1: plain command byte
        cmd(8'hAE);

        // 2: 4x2 window, 10 pixels wrap back to the window origin
        cmd(8'h15); dat(8'h10); dat(8'h13);
        cmd(8'h75); dat(8'h20); dat(8'h21);
        cmd(8'h5C);
        for (int i = 0; i < 10; i++)
            pixel(t2_addr[i], 16'(i + 1), (i == 7));

        // 3: after reset the first pixel lands at 0; then park the pointer at
        //    (127,127) inside a full window and cross the frame boundary
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(4);
        cmd(8'h5C);
        pixel(14'h0000, 16'hF800, 1'b0);
        cmd(8'h15); dat(8'h7F); dat(8'h7F);
        cmd(8'h15); dat(8'h00);
        cmd(8'h75); dat(8'h7F); dat(8'h7F);
        cmd(8'h75); dat(8'h00);
        cmd(8'h5C);
        pixel(14'h3FFF, 16'h1111, 1'b1);
        pixel(14'h0000, 16'h2222, 1'b0);
        pixel(14'h0001, 16'h3333, 1'b0);

        // 4: start clamps to 127, inverted end collapses onto it; row is 0
        cmd(8'h15); dat(8'hFF); dat(8'h00);
        cmd(8'h5C);
        pixel(14'd127, 16'hABCD, 1'b0);

        // 5: partial byte aborted, then normal decode and pixel (row advanced to 1)
        dcb = 1'b0;
        tick(2);
        csb = 1'b0;
        tick(2);
        n_abort_exp++;
        shift_bits(8'hA5, 5);
        tick(2);
        csb = 1'b1;
        tick(6);
        cmd(8'h5C);
        pixel(14'd255, 16'h1234, 1'b0);

        // 6: a command between pixel bytes discards the pending high byte
        cmd(8'h5C);
        dat(8'h12);
        cmd(8'hAF);
        cmd(8'h5C);
        pixel(14'h017F, 16'h3456, 1'b0);

        // 6b: shrink to a one-column window, then reset mid-byte
        cmd(8'h15); dat(8'h00); dat(8'h00);
        dcb = 1'b1;
        tick(2);
        csb = 1'b0;
        tick(2);
        shift_bits(8'hC3, 3);
        rst_n = 1'b0;
        #1;
        check_all_zero("midbyte_reset");
        tick(1);
        csb = 1'b1;
        sck = 1'b1;
        tick(3);
        rst_n = 1'b1;
        tick(4);
        // Restored default window: the second pixel is at col 1, not row 1
        cmd(8'h5C);
        pixel(14'h0000, 16'h0102, 1'b0);
        pixel(14'h0001, 16'h0304, 1'b0);

        wait_cnt = 0;
        while ((q_rx.size() != 0 || q_pix.size() != 0 || n_abort_exp != 0) && wait_cnt < 200) begin
            tick(1);
            wait_cnt++;
        end
        tick(10);
        chk("rx_queue_drained", 32'(q_rx.size()), 32'h0);
        chk("pix_queue_drained", 32'(q_pix.size()), 32'h0);
        chk("abort_seen", 32'(n_abort_exp), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
